// File: rtl/vdic_mult_pkg.sv
// Shared types and constants for the req/ack multiply responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Macro VDIC_MULT_SINGLE_CYCLE_EN selects the single-cycle product path (MULT_LATENCY = 1).
package vdic_mult_pkg;

  localparam int DATA_W_DEF = 16;

`ifdef VDIC_MULT_SINGLE_CYCLE_EN
  localparam int MULT_LATENCY = 1;
`else
  localparam int MULT_LATENCY = DATA_W_DEF + 1;
`endif

  // Widest operand the parity helper accepts; narrower operands are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int PAR_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MULT,
    DONE,
    REL
  } state_t;

  // Even parity: data plus its parity bit must XOR to zero.
  function automatic logic parity_err(input logic [PAR_W-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier datapath, one recoding step per clock.
// Latency: start edge loads operands, product is presented with done on the W-th step.
// Backpressure: none; start restarts the datapath unconditionally.
// Ports: clk, rst_n; start, mcand, mplier (load); busy, done (last step this cycle), product.
module booth_mult_seq #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_nxt;
  logic [2*W-1:0] mc;      // multiplicand, sign-extended and shifted left once per step
  logic [W-1:0]   q;       // multiplier, shifted right once per step
  logic           q_m1;    // previously examined multiplier bit
  logic [CW-1:0]  cnt;

  // Booth recoding of the bit pair {q_i, q_(i-1)}: 01 adds, 10 subtracts.
  // The top step subtracts for a set sign bit, which yields the signed product
  // modulo 2^(2W); the largest magnitude (-2^(W-1))^2 still fits.
  always_comb begin
    acc_nxt = acc;
    case ({q[0], q_m1})
      2'b01:   acc_nxt = acc + mc;
      2'b10:   acc_nxt = acc - mc;
      default: acc_nxt = acc;
    endcase
  end

  assign done    = busy && (cnt == CW'(W - 1));
  // The final accumulation is exposed combinationally so the caller can register
  // it on the same edge that completes the last step.
  assign product = acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      mc   <= '0;
      q    <= '0;
      q_m1 <= 1'b0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      acc  <= '0;
      mc   <= {{W{mcand[W-1]}}, mcand};
      q    <= mplier;
      q_m1 <= 1'b0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc  <= acc_nxt;
      mc   <= mc << 1;
      q    <= q >> 1;
      q_m1 <= q[0];
      cnt  <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vdic_mult_responder.sv
// Responder side of the req/ack multiply protocol with operand parity checking.
// Latency: ack 1 edge after capture; result_rdy 17 edges after capture (1 on parity error or single-cycle build).
// Backpressure: req is a held level; one capture per request, next capture only after req drops.
// Ports: clk, rst_n; arg_a/arg_b with parity bits, req in; ack, result, result_parity,
//        arg_parity_error, result_rdy out. Macro VDIC_MULT_SINGLE_CYCLE_EN removes the MULT state.
module vdic_mult_responder
  import vdic_mult_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   arg_a,
  input  logic                arg_a_parity,
  input  logic [DATA_W-1:0]   arg_b,
  input  logic                arg_b_parity,
  input  logic                req,
  output logic                ack,
  output logic [2*DATA_W-1:0] result,
  output logic                result_parity,
  output logic                arg_parity_error,
  output logic                result_rdy
);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                a_par_q, b_par_q;
  logic                capture;
  logic                ack_nxt, rdy_nxt, rpar_nxt, perr_nxt;
  logic [2*DATA_W-1:0] result_nxt;
  logic                perr_now;

  assign perr_now = parity_err(PAR_W'(a_q), a_par_q) | parity_err(PAR_W'(b_q), b_par_q);

`ifdef VDIC_MULT_SINGLE_CYCLE_EN
  logic [2*DATA_W-1:0] prod_sc;
  // Both operands widened to the result width so the low half of the product is exact.
  assign prod_sc = $signed({{DATA_W{a_q[DATA_W-1]}}, a_q}) * $signed({{DATA_W{b_q[DATA_W-1]}}, b_q});
`else
  logic                booth_start;
  logic                booth_busy;
  logic                booth_done;
  logic [2*DATA_W-1:0] booth_product;

  booth_mult_seq #(.W(DATA_W)) u_booth (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (booth_start),
    .mcand   (a_q),
    .mplier  (b_q),
    .busy    (booth_busy),
    .done    (booth_done),
    .product (booth_product)
  );
`endif

  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    ack_nxt    = 1'b0;
    rdy_nxt    = 1'b0;
    result_nxt = result;
    rpar_nxt   = result_parity;
    perr_nxt   = arg_parity_error;
`ifndef VDIC_MULT_SINGLE_CYCLE_EN
    booth_start = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req) begin
          capture   = 1'b1;
          ack_nxt   = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (perr_now) begin
          result_nxt = '0;
          rpar_nxt   = 1'b0;
          perr_nxt   = 1'b1;
          rdy_nxt    = 1'b1;
          state_nxt  = DONE;
        end else begin
          perr_nxt = 1'b0;
`ifdef VDIC_MULT_SINGLE_CYCLE_EN
          result_nxt = prod_sc;
          rpar_nxt   = ^prod_sc;
          rdy_nxt    = 1'b1;
          state_nxt  = DONE;
`else
          booth_start = 1'b1;
          state_nxt   = MULT;
`endif
        end
      end
`ifndef VDIC_MULT_SINGLE_CYCLE_EN
      MULT: begin
        if (booth_done) begin
          result_nxt = booth_product;
          rpar_nxt   = ^booth_product;
          rdy_nxt    = 1'b1;
          state_nxt  = DONE;
        end else if (!booth_busy) begin
          // Datapath idle without having finished: recover rather than hang.
          state_nxt = IDLE;
        end
      end
`endif
      DONE: begin
        state_nxt = req ? REL : IDLE;
      end
      REL: begin
        if (!req) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      ack              <= 1'b0;
      result_rdy       <= 1'b0;
      result           <= '0;
      result_parity    <= 1'b0;
      arg_parity_error <= 1'b0;
      a_q              <= '0;
      b_q              <= '0;
      a_par_q          <= 1'b0;
      b_par_q          <= 1'b0;
    end else begin
      state            <= state_nxt;
      ack              <= ack_nxt;
      result_rdy       <= rdy_nxt;
      result           <= result_nxt;
      result_parity    <= rpar_nxt;
      arg_parity_error <= perr_nxt;
      if (capture) begin
        a_q     <= arg_a;
        b_q     <= arg_b;
        a_par_q <= arg_a_parity;
        b_par_q <= arg_b_parity;
      end
    end
  end

endmodule

// File: tb/tb_vdic_mult_responder.sv
// Directed plus randomized bench for vdic_mult_responder against an arithmetic reference.
// Latency: expects 17-edge valid latency, or 1 edge with VDIC_MULT_SINGLE_CYCLE_EN.
// Backpressure: requester holds req until ack, then drops it (except in the held-req step).
module tb_vdic_mult_responder;

  localparam int W = 16;
`ifdef VDIC_MULT_SINGLE_CYCLE_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = W + 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  arg_a = '0;
  logic          arg_a_parity = 1'b0;
  logic [W-1:0]  arg_b = '0;
  logic          arg_b_parity = 1'b0;
  logic          req = 1'b0;
  logic          ack;
  logic [2*W-1:0] result;
  logic          result_parity;
  logic          arg_parity_error;
  logic          result_rdy;

  int checks = 0;
  int errors = 0;

  // Reference state of the held outputs.
  logic [31:0] last_res = '0;
  logic        last_rpar = 1'b0;
  logic        last_err = 1'b0;

  always #5 clk = ~clk;

  vdic_mult_responder #(.DATA_W(W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .arg_a            (arg_a),
    .arg_a_parity     (arg_a_parity),
    .arg_b            (arg_b),
    .arg_b_parity     (arg_b_parity),
    .req              (req),
    .ack              (ack),
    .result           (result),
    .result_parity    (result_parity),
    .arg_parity_error (arg_parity_error),
    .result_rdy       (result_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b);
    longint pa, pb, p;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    p  = pa * pb;
    return p[31:0];
  endfunction

  function automatic logic par16(input logic [15:0] x);
    return ^x;
  endfunction

  // Wait (bounded) for result_rdy; n = edges counted from the capture edge.
  task automatic wait_rdy(output bit got, output int n);
    got = 1'b0;
    n = 1;
    while (!got && n <= 40) begin
      @(posedge clk); #1;
      if (result_rdy === 1'b1) got = 1'b1;
      else n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic ap,
                              input logic [15:0] b, input logic bp, input int n, input bit got);
    logic        eerr;
    logic [31:0] er;
    int          lat;
    eerr = (par16(a) != ap) || (par16(b) != bp);
    er   = eerr ? 32'h0 : model_prod(a, b);
    lat  = eerr ? 1 : EXP_LAT;
    chk({tag, " rdy seen"}, 32'(got), 32'd1);
    chk({tag, " latency"}, n, lat);
    chk({tag, " result"}, result, er);
    chk({tag, " result_parity"}, 32'(result_parity), 32'(^er));
    chk({tag, " parity_error"}, 32'(arg_parity_error), 32'(eerr));
    chk({tag, " ack low at rdy"}, 32'(ack), 32'd0);
    last_res  = er;
    last_rpar = ^er;
    last_err  = eerr;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic ap,
                        input logic [15:0] b, input logic bp);
    bit got;
    int n;
    @(negedge clk);
    arg_a = a; arg_a_parity = ap; arg_b = b; arg_b_parity = bp; req = 1'b1;
    @(posedge clk); #1;
    chk({tag, " ack"}, 32'(ack), 32'd1);
    chk({tag, " held result"}, result, last_res);
    chk({tag, " held parity_error"}, 32'(arg_parity_error), 32'(last_err));
    @(negedge clk);
    // Operands scrambled after capture must not affect the outcome.
    req = 1'b0;
    arg_a = 16'($urandom); arg_b = 16'($urandom);
    arg_a_parity = 1'($urandom); arg_b_parity = 1'($urandom);
    wait_rdy(got, n);
    check_result(tag, a, ap, b, bp, n, got);
    @(posedge clk); #1;
    chk({tag, " rdy pulse"}, 32'(result_rdy), 32'd0);
    chk({tag, " result hold"}, result, last_res);
    chk({tag, " parity hold"}, 32'(result_parity), 32'(last_rpar));
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rap, rbp;
    bit          got;
    int          n, acks, rdys;

    // Reset state.
    #2;
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset result_parity", 32'(result_parity), 32'd0);
    chk("reset parity_error", 32'(arg_parity_error), 32'd0);
    chk("reset rdy", 32'(result_rdy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed products.
    run_op("3x-5", 16'd3, par16(16'd3), 16'hFFFB, par16(16'hFFFB));
    run_op("7fff^2", 16'h7FFF, par16(16'h7FFF), 16'h7FFF, par16(16'h7FFF));
    run_op("8000^2", 16'h8000, par16(16'h8000), 16'h8000, par16(16'h8000));
    run_op("8fff^2", 16'h8FFF, par16(16'h8FFF), 16'h8FFF, par16(16'h8FFF));
    run_op("-7x6", 16'hFFF9, par16(16'hFFF9), 16'd6, par16(16'd6));

    // Parity errors: bad a, bad b, both bad.
    run_op("bad a", 16'd1, 1'b0, 16'd2, par16(16'd2));
    run_op("ok after err", 16'd100, par16(16'd100), 16'hFF00, par16(16'hFF00));
    run_op("bad b", 16'd1, par16(16'd1), 16'd2, ~par16(16'd2));
    run_op("bad both", 16'd1, 1'b0, 16'd2, ~par16(16'd2));

    // Randomized operations, roughly one in four operands with a wrong parity bit.
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rap = par16(ra) ^ ($urandom_range(3) == 0);
      rbp = par16(rb) ^ ($urandom_range(3) == 0);
      run_op($sformatf("rand%0d", i), ra, rap, rb, rbp);
    end

    // req held through result_rdy and 5 more cycles: exactly one capture.
    @(negedge clk);
    arg_a = 16'h1357; arg_a_parity = par16(16'h1357);
    arg_b = 16'hF00D; arg_b_parity = par16(16'hF00D);
    req = 1'b1;
    acks = 0; rdys = 0; got = 1'b0; n = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      acks += int'(ack);
      rdys += int'(result_rdy);
      if (result_rdy === 1'b1) got = 1'b1;
    end
    chk("held req rdy seen", 32'(got), 32'd1);
    chk("held req result", result, model_prod(16'h1357, 16'hF00D));
    repeat (5) begin
      @(posedge clk); #1;
      acks += int'(ack);
      rdys += int'(result_rdy);
    end
    chk("held req ack count", acks, 1);
    chk("held req rdy count", rdys, 1);
    last_res = model_prod(16'h1357, 16'hF00D);
    last_rpar = ^last_res;
    last_err = 1'b0;
    // One low cycle of req, then a new request must be acknowledged.
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    arg_a = 16'h0042; arg_a_parity = par16(16'h0042);
    arg_b = 16'hFFFE; arg_b_parity = par16(16'hFFFE);
    req = 1'b1;
    @(posedge clk); #1;
    chk("re-request ack", 32'(ack), 32'd1);
    @(negedge clk); req = 1'b0;
    wait_rdy(got, n);
    check_result("re-request", 16'h0042, par16(16'h0042), 16'hFFFE, par16(16'hFFFE), n, got);
    @(posedge clk); #1;

    // Reset during the 5th MULT cycle aborts the operation.
    @(negedge clk);
    arg_a = 16'h1234; arg_a_parity = par16(16'h1234);
    arg_b = 16'h0F0F; arg_b_parity = par16(16'h0F0F);
    req = 1'b1;
    @(posedge clk); #1;
    chk("abort ack", 32'(ack), 32'd1);
    @(negedge clk); req = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("abort pre-reset result hold", result, last_res);
    rst_n = 1'b0;
    #1;
    chk("abort ack", 32'(ack), 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort result_parity", 32'(result_parity), 32'd0);
    chk("abort parity_error", 32'(arg_parity_error), 32'd0);
    chk("abort rdy", 32'(result_rdy), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    acks = 0; rdys = 0;
    repeat (25) begin
      @(posedge clk); #1;
      acks += int'(ack);
      rdys += int'(result_rdy);
    end
    chk("abort no late rdy", rdys, 0);
    chk("abort no late ack", acks, 0);
    last_res = '0; last_rpar = 1'b0; last_err = 1'b0;
    run_op("post-reset 2x2", 16'd2, par16(16'd2), 16'd2, par16(16'd2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vdic_mult_responder.md
Name: vdic_mult_responder

Overview:
- Responder end of the req/ack multiply protocol: accepts two signed 16-bit operands with even-parity bits and returns a signed 32-bit product with its parity bit.
- Contains an iterative radix-2 Booth multiplier with operand parity checking.
- Sits behind any requester that drives req, waits for ack, then waits for result_rdy.

Parameters:
- DATA_W, 16, operand width; result width is 2*DATA_W; iteration count is DATA_W.

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst_n  input  1  reset, asynchronous, active-low
- arg_a  input  DATA_W  signed operand A
- arg_a_parity  input  1  parity bit for arg_a; valid when equal to ^arg_a
- arg_b  input  DATA_W  signed operand B
- arg_b_parity  input  1  parity bit for arg_b; valid when equal to ^arg_b
- req  input  1  request; level, held by requester until ack is seen
- ack  output  1  one-cycle pulse, operands captured
- result  output  2*DATA_W  signed product; 0 on parity error
- result_parity  output  1  ^result
- arg_parity_error  output  1  1 when either operand parity check failed
- result_rdy  output  1  one-cycle pulse, result and flags valid

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0: state=IDLE, and ack, result, result_parity, arg_parity_error and result_rdy are all 0.
- A reset asserted mid-operation aborts the operation immediately. No partial result is ever reported.
- States: IDLE, CHECK, MULT, DONE, REL.
- IDLE: at posedge N with req=1:
  - register arg_a, arg_b and both parity bits;
  - ack<=1; state<=CHECK.
- CHECK (edge N+1): ack<=0.
  - Parity error (either operand), i.e. ^{arg_x, arg_x_parity}=1: result<=0, result_parity<=0, arg_parity_error<=1, result_rdy<=1, state<=DONE.
  - Otherwise: arg_parity_error<=0, clear accumulator, count<=0, state<=MULT.
- MULT: one Booth step per cycle for DATA_W cycles (edges N+2..N+17).
  - Arithmetic is two's complement, sign-extended.
  - The final step loads result, sets result_parity=^product and result_rdy<=1, state<=DONE.
  - -32768*-32768 must give 0x40000000 (no overflow at 2*DATA_W).
- Latency: ack visible 1 edge after capture. result_rdy visible after edge N+17 for a valid operation and after edge N+1 on a parity error.
- DONE: result_rdy<=0. If req=0, state<=IDLE; else state<=REL.
- REL: stay until req=0, then IDLE. A request held high never triggers a second capture.
- result, result_parity and arg_parity_error hold their values until the next CHECK/MULT completion or reset.
- Operand changes after capture are ignored. req deasserted during CHECK/MULT is ignored; the operation completes.
- ack and result_rdy are never high in the same cycle.

Optional Feature:
- Macro: VDIC_MULT_SINGLE_CYCLE_EN.
- Defined: the MULT state is removed. CHECK computes the product combinationally (arg_a*arg_b, signed) and loads result with result_rdy<=1 at edge N+1, so valid latency equals parity-error latency.
- Undefined: the iterative Booth path above, 17-edge latency.
- Handshake, parity and REL behaviour are identical in both builds.

Decomposition:
- Package vdic_mult_pkg holds:
  - state enum (IDLE, CHECK, MULT, DONE, REL);
  - DATA_W default;
  - MULT_LATENCY constant (DATA_W+1, or 1 with the macro defined);
  - function for parity check.
- Sub-module booth_mult_seq: start/busy/done datapath holding the accumulator, multiplier shift register and counter.
- Top-level FSM, ack/result_rdy generation and parity checking stay in vdic_mult_responder.

Test Plan:
- a=3, b=-5, correct parities, req high one cycle before ack -> ack 1 cycle after capture; result_rdy after 17 edges; result=0xFFFFFFF1, result_parity=1, arg_parity_error=0.
- a=0x7FFF, b=0x7FFF -> result=0x3FFF0001, parity=1. a=0x8000, b=0x8000 -> 0x40000000, parity=1. a=0x8FFF, b=0x8FFF -> 0x3100E001, parity=1.
- a=0x0001 with arg_a_parity=0, b=0x0002 valid -> result_rdy 1 edge after CHECK; result=0, result_parity=0, arg_parity_error=1. Repeat with bad b only, and with both bad: same response.
- req held high through result_rdy and 5 further cycles -> exactly one ack; after req=0 for 1 cycle then req=1, a new ack follows.
- rst_n pulled low in the 5th MULT cycle -> all outputs 0 asynchronously; after release, a=2, b=2 -> result=4 with normal latency.
- With VDIC_MULT_SINGLE_CYCLE_EN defined, a=-7, b=6 -> result_rdy 1 edge after CHECK entry; result=0xFFFFFFD6, parity=1.
